// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// ---------------
// 4-wire SPI master (CPOL=0, MSB first) that runs one frame per accepted
// write/read command strobe from the register file. The captured read
// word is returned right-justified on spi_rdata.
//
// Optional build macro: SPI_MISO_SYNC_EN
//   defined   - spi_miso passes through a two-flop synchronizer, and each
//               capture is taken two clk cycles after the sampling SCLK
//               edge (needs CLK_DIV >= 3).
//   undefined - spi_miso is registered on the clk edge that produces the
//               sampling SCLK edge.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   spi_wr_en/rd_en   single-cycle command strobes (ignored while busy)
//   spi_wdata         transmit word, right-justified
//   spi_rw_len        frame length minus one (1..32 bits)
//   spi_d_rise_align  0: launch on SCLK fall, sample on rise; 1: opposite
//   spi_rdata         captured read word, right-justified
//   spi_busy          command accept through end of inter-frame gap
//   spi_done          one-cycle pulse at end of frame
//   spi_csb/sclk/mosi SPI bus outputs, all registered
//   spi_miso          SPI serial input
module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_wr_en,
    input  logic        spi_rd_en,
    input  logic [31:0] spi_wdata,
    input  logic [4:0]  spi_rw_len,
    input  logic        spi_d_rise_align,
    output logic [31:0] spi_rdata,
    output logic        spi_busy,
    output logic        spi_done,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_hi_q, phase_hi_d;
    logic [4:0]  len_q, len_d;
    logic        align_q, align_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        csb_q, csb_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;

    logic        sample_now;
    logic        cap_en;
    logic        cap_bit;
    logic        mosi_valid;
    logic [4:0]  mosi_idx;

    // Outputs are computed from the current state and registered, so the
    // bus lags the state register by one clk. sample_now marks the clk
    // edge that will produce the sampling SCLK edge. The last falling edge
    // of a frame happens on entry to HOLD, which acts as pulse N's low phase.
    always_comb begin
        sample_now = 1'b0;
        if (state_q == SHIFT && cnt_q == 8'd0) begin
            sample_now = align_q ? !phase_hi_q : phase_hi_q;
        end
        if (state_q == HOLD && cnt_q == 8'd0 && align_q) begin
            sample_now = 1'b1;
        end
    end

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync_q, miso_sync_d;
    logic [1:0] cap_pipe_q, cap_pipe_d;

    // The capture strobe is delayed by the synchronizer depth so it lines
    // up with the MISO value present at the sampling SCLK edge.
    always_comb begin
        miso_sync_d = {miso_sync_q[0], spi_miso};
        cap_pipe_d  = {cap_pipe_q[0], sample_now};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sync_q <= 2'b00;
            cap_pipe_q  <= 2'b00;
        end else begin
            miso_sync_q <= miso_sync_d;
            cap_pipe_q  <= cap_pipe_d;
        end
    end

    assign cap_en  = cap_pipe_q[1];
    assign cap_bit = miso_sync_q[1];
`else
    assign cap_en  = sample_now;
    assign cap_bit = spi_miso;
`endif

    // Next-state logic. The transmit word is stored left-justified so the
    // bit on the wire is always tx_q[31 - bit index].
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        phase_hi_d = phase_hi_q;
        len_d      = len_q;
        align_d    = align_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;

        if (cap_en) begin
            rx_d = {rx_q[30:0], cap_bit};
        end

        unique case (state_q)
            IDLE: begin
                if (!busy_q && (spi_wr_en || spi_rd_en)) begin
                    len_d   = spi_rw_len;
                    align_d = spi_d_rise_align;
                    wr_d    = spi_wr_en;
                    rd_d    = spi_rd_en;
                    tx_d    = spi_wdata << (5'd31 - spi_rw_len);
                    rx_d    = 32'd0;
                    cnt_d   = 8'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d      = 8'd0;
                    bit_d      = 5'd0;
                    phase_hi_d = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (phase_hi_q) begin
                        if (bit_q == len_q) begin
                            state_d = HOLD;
                        end else begin
                            phase_hi_d = 1'b0;
                        end
                    end else begin
                        phase_hi_d = 1'b1;
                        bit_d      = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0 && rd_q) begin
                    rdata_d = rx_q;
                end
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs. With align=0 the next bit is launched on the falling
    // edge, so the low phase already carries bit+1; with align=1 MOSI is
    // idle in SETUP and the last bit is held through HOLD for the slave's
    // falling-edge sample.
    always_comb begin
        busy_d     = (state_q != IDLE);
        csb_d      = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
        sclk_d     = (state_q == SHIFT) && phase_hi_q;
        done_d     = (state_q == GAP) && (cnt_q == 8'd0);
        mosi_valid = 1'b0;
        mosi_idx   = bit_q;
        unique case (state_q)
            SETUP: begin
                mosi_valid = !align_q;
                mosi_idx   = 5'd0;
            end
            SHIFT: begin
                mosi_valid = 1'b1;
                if (!phase_hi_q && !align_q) begin
                    mosi_idx = bit_q + 5'd1;
                end
            end
            HOLD: begin
                mosi_valid = align_q;
                mosi_idx   = len_q;
            end
            default: begin
                mosi_valid = 1'b0;
            end
        endcase
        mosi_d = wr_q && mosi_valid && tx_q[5'd31 - mosi_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 5'd0;
            phase_hi_q <= 1'b0;
            len_q      <= 5'd0;
            align_q    <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= 32'd0;
            rx_q       <= 32'd0;
            rdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_hi_q <= phase_hi_d;
            len_q      <= len_d;
            align_q    <= align_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign spi_rdata = rdata_q;
    assign spi_busy  = busy_q;
    assign spi_done  = done_q;
    assign spi_csb   = csb_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// ------------------
// Directed and random frames against spi_master_ctrl. A small SPI slave
// model drives MISO from a word (or loops MOSI back), and the expected
// frame timing, MOSI word and captured read word are worked out from the
// frame length, CLK_DIV and the command flags.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_wr_en;
    logic        spi_rd_en;
    logic [31:0] spi_wdata;
    logic [4:0]  spi_rw_len;
    logic        spi_d_rise_align;
    logic [31:0] spi_rdata;
    logic        spi_busy;
    logic        spi_done;
    logic        spi_csb;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    int          assert_count = 0;
    int          fail_count   = 0;
    logic [31:0] exp_rdata    = 32'd0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk              (clk),
        .rst              (rst),
        .spi_wr_en        (spi_wr_en),
        .spi_rd_en        (spi_rd_en),
        .spi_wdata        (spi_wdata),
        .spi_rw_len       (spi_rw_len),
        .spi_d_rise_align (spi_d_rise_align),
        .spi_rdata        (spi_rdata),
        .spi_busy         (spi_busy),
        .spi_done         (spi_done),
        .spi_csb          (spi_csb),
        .spi_sclk         (spi_sclk),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command and watches the whole frame at negedges.
    // Cycle index k counts negedges after the accepting edge T, so an event
    // registered at edge T+j is seen at k = j.
    task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                                 input logic [31:0] wdata, input logic [4:0] len,
                                 input logic align, input logic [31:0] miso_word,
                                 input logic loopback, input int late_strobe_at,
                                 input int abort_at_rise);
        int          n, budget, rises, samples, done_cnt, csb_falls, unstable, slave_idx;
        int          k_csb_low, k_busy_rise, k_first_rise, k_done, k_csb_high, k_busy_fall, k_abort;
        logic [31:0] mask, exp_mosi, mosi_word, rdata_at_done;
        logic        mosi_entry, prev_sclk, prev_csb, prev_busy, prev_mosi, aborted;

        n        = int'(len) + 1;
        budget   = DIV * (2 * n + 2) + 12;
        mask     = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        exp_mosi = wr ? (wdata & mask) : 32'd0;
        rises = 0; samples = 0; done_cnt = 0; csb_falls = 0; unstable = 0; slave_idx = 0;
        k_csb_low = -1; k_busy_rise = -1; k_first_rise = -1; k_done = -1;
        k_csb_high = -1; k_busy_fall = -1; k_abort = -1;
        mosi_word = 32'd0; rdata_at_done = 32'd0; mosi_entry = 1'bx; aborted = 1'b0;

        @(negedge clk);
        spi_wr_en        = wr;
        spi_rd_en        = rd;
        spi_wdata        = wdata;
        spi_rw_len       = len;
        spi_d_rise_align = align;
        spi_miso         = 1'($urandom);
        prev_sclk = spi_sclk; prev_csb = spi_csb; prev_busy = spi_busy; prev_mosi = spi_mosi;
        @(posedge clk);

        for (int k = 0; k <= budget; k++) begin
            @(negedge clk);
            if (k == 0) begin
                spi_wr_en        = 1'b0;
                spi_rd_en        = 1'b0;
                spi_wdata        = $urandom;
                spi_rw_len       = 5'($urandom);
                spi_d_rise_align = 1'($urandom);
            end
            if (late_strobe_at != 0 && k == late_strobe_at)     spi_wr_en = 1'b1;
            if (late_strobe_at != 0 && k == late_strobe_at + 1) spi_wr_en = 1'b0;
            if (aborted && k == k_abort + 1) rst = 1'b0;

            if (k == 1) mosi_entry = spi_mosi;
            if (!prev_busy && spi_busy && k_busy_rise < 0) k_busy_rise = k;
            if (prev_busy && !spi_busy && k_busy_fall < 0) k_busy_fall = k;
            if (!prev_csb && spi_csb && k_csb_high < 0)    k_csb_high = k;
            if (prev_csb && !spi_csb) begin
                csb_falls++;
                if (k_csb_low < 0) k_csb_low = k;
                slave_idx = 0;
                if (!align) spi_miso = miso_word[n - 1];
            end
            if (!prev_sclk && spi_sclk) begin
                rises++;
                if (k_first_rise < 0) k_first_rise = k;
                if (!align) begin
                    if (spi_mosi !== prev_mosi) unstable++;
                    mosi_word = {mosi_word[30:0], spi_mosi};
                    samples++;
                end else begin
                    if (slave_idx < n) spi_miso = miso_word[n - 1 - slave_idx];
                    slave_idx++;
                end
            end
            if (prev_sclk && !spi_sclk) begin
                if (align) begin
                    if (spi_mosi !== prev_mosi) unstable++;
                    mosi_word = {mosi_word[30:0], spi_mosi};
                    samples++;
                end else begin
                    slave_idx++;
                    if (slave_idx < n) spi_miso = miso_word[n - 1 - slave_idx];
                end
            end
            if (spi_done) begin
                done_cnt++;
                k_done        = k;
                rdata_at_done = spi_rdata;
            end
            if (loopback) spi_miso = spi_mosi;

            if (!aborted && abort_at_rise != 0 && rises == abort_at_rise) begin
                rst = 1'b1;
                #1;
                exp_rdata = 32'd0;
                checkOutput({tag, ".rst_csb"},   64'(spi_csb),   64'd1);
                checkOutput({tag, ".rst_sclk"},  64'(spi_sclk),  64'd0);
                checkOutput({tag, ".rst_busy"},  64'(spi_busy),  64'd0);
                checkOutput({tag, ".rst_mosi"},  64'(spi_mosi),  64'd0);
                checkOutput({tag, ".rst_rdata"}, 64'(spi_rdata), 64'(exp_rdata));
                aborted = 1'b1;
                k_abort = k;
            end

            prev_sclk = spi_sclk; prev_csb = spi_csb; prev_busy = spi_busy; prev_mosi = spi_mosi;
            if (aborted && k == k_abort + 4 * DIV) break;
            if (!aborted && k_busy_fall >= 0 && k == k_busy_fall + 4) break;
        end

        if (aborted) begin
            checkOutput({tag, ".abort_done"},  64'(done_cnt), 64'd0);
            checkOutput({tag, ".abort_rises"}, 64'(rises),    64'(abort_at_rise));
            checkOutput({tag, ".abort_csb"},   64'(spi_csb),  64'd1);
        end else begin
            if (rd) exp_rdata = loopback ? exp_mosi : (miso_word & mask);
            checkOutput({tag, ".csb_low_at"},    64'(k_csb_low),    64'd1);
            checkOutput({tag, ".busy_rise_at"},  64'(k_busy_rise),  64'd1);
            checkOutput({tag, ".first_rise_at"}, 64'(k_first_rise), 64'(1 + DIV));
            checkOutput({tag, ".sclk_pulses"},   64'(rises),        64'(n));
            checkOutput({tag, ".done_count"},    64'(done_cnt),     64'd1);
            checkOutput({tag, ".done_at"},       64'(k_done),       64'(1 + DIV * (2 * n + 1)));
            checkOutput({tag, ".csb_high_at"},   64'(k_csb_high),   64'(1 + DIV * (2 * n + 1)));
            checkOutput({tag, ".busy_fall_at"},  64'(k_busy_fall),  64'(1 + DIV * (2 * n + 2)));
            checkOutput({tag, ".csb_frames"},    64'(csb_falls),    64'd1);
            checkOutput({tag, ".mosi_samples"},  64'(samples),      64'(n));
            checkOutput({tag, ".mosi_word"},     64'(mosi_word),    64'(exp_mosi));
            checkOutput({tag, ".mosi_stable"},   64'(unstable),     64'd0);
            checkOutput({tag, ".mosi_entry"},    64'(mosi_entry),
                        64'((align || !wr) ? 1'b0 : wdata[n - 1]));
            checkOutput({tag, ".rdata_at_done"}, 64'(rdata_at_done), 64'(exp_rdata));
            checkOutput({tag, ".rdata_after"},   64'(spi_rdata),     64'(exp_rdata));
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] rw, rm;

        rst              = 1'b1;
        spi_wr_en        = 1'b0;
        spi_rd_en        = 1'b0;
        spi_wdata        = 32'd0;
        spi_rw_len       = 5'd0;
        spi_d_rise_align = 1'b0;
        spi_miso         = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.rdata", 64'(spi_rdata), 64'd0);
        checkOutput("reset.busy",  64'(spi_busy),  64'd0);
        checkOutput("reset.done",  64'(spi_done),  64'd0);
        checkOutput("reset.csb",   64'(spi_csb),   64'd1);
        checkOutput("reset.sclk",  64'(spi_sclk),  64'd0);
        checkOutput("reset.mosi",  64'(spi_mosi),  64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] write 0xA5, 8 bits, align=0");
        applyStimulus("wr_a5", 1'b1, 1'b0, 32'h0000_00A5, 5'd7, 1'b0, $urandom, 1'b0, 0, 0);

        $display("[TB] read 32 bits of 0xDEADBEEF");
        applyStimulus("rd_32", 1'b0, 1'b1, $urandom, 5'd31, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 0);

        $display("[TB] read 1 bit, align=1");
        applyStimulus("rd_1", 1'b0, 1'b1, $urandom, 5'd0, 1'b1, 32'h0000_0001, 1'b0, 0, 0);

        $display("[TB] write strobe while busy");
        applyStimulus("busy_strobe", 1'b1, 1'b0, 32'h0000_5A5A, 5'd15, 1'b0, $urandom, 1'b0, 5, 0);

        $display("[TB] reset during bit 5 of a 16-bit frame");
        applyStimulus("abort", 1'b1, 1'b1, 32'h0000_FFFF, 5'd15, 1'b0, 32'h0000_BEEF, 1'b0, 0, 6);
        applyStimulus("after_rst", 1'b1, 1'b0, 32'h0000_1234, 5'd15, 1'b0, $urandom, 1'b0, 0, 0);

        $display("[TB] full duplex loopback 0x3C");
        applyStimulus("duplex", 1'b1, 1'b1, 32'h0000_003C, 5'd7, 1'b0, 32'd0, 1'b1, 0, 0);

        $display("[TB] random frames");
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(1, 3));
            rw = $urandom;
            rm = $urandom;
            applyStimulus($sformatf("rand%0d", i), op[0], op[1], rw, 5'($urandom),
                          1'($urandom), rm, 1'b0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
